rf_write_arbiter: RTL

Shares the register file's single write port (`data_in`/`Rd`/`we`) between `NREQ` writeback requesters, such as the ALU result path and the load-return path of the multi-cycle core. Each cycle it grants at most one valid requester in round-robin order and captures that request in a registered write stage that drives the register file. Writes to x0 are accepted and dropped. It also exports a one-hot view of the destination register currently being written, which hazard and bypass logic use.

---
 rtl/rf_write_arbiter_pkg.sv | 17 +
 rtl/rf_write_arbiter_rr_arbiter.sv | 60 ++++++
 rtl/rf_write_arbiter.sv | 86 ++++++++
 3 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared core definitions for the register-file writeback path: architectural widths
// and the round-robin index helper used by the write-port arbiter.
package rf_write_arbiter_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned XLEN = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    // Index following idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: holds the priority pointer and computes a one-hot grant to the
// first valid requester at or after the pointer, wrapping around.
module rr_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          valid,
    input  logic                     advance,
    output logic [NREQ-1:0]          grant_onehot,
    output logic [$clog2(NREQ)-1:0]  grant_idx
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand;
    logic          found;
    int unsigned   sum;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand         = '0;
        sum          = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = 32'(ptr_q) + k;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            cand = IW'(sum);
            if (!found && valid[cand]) begin
                found              = 1'b1;
                grant_onehot[cand] = 1'b1;
                grant_idx          = cand;
            end
        end
    end

    // The pointer moves past the winner only when the grant was actually taken.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = IW'(rr_next(32'(grant_idx), NREQ));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port among NREQ writeback requesters, with a
// registered write stage and a one-hot view of the register currently being written.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned DW   = XLEN,
    parameter int unsigned AW   = REG_AW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hold,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*AW-1:0]       req_rd,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_rd,
    output logic [DW-1:0]            rf_data,
    output logic [(2**AW)-1:0]       wr_pending,
    output logic [$clog2(NREQ)-1:0]  grant_idx
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [NREQ-1:0] arb_onehot;
    logic [IW-1:0]   arb_idx;
    logic            transfer;
    logic [AW-1:0]   sel_rd;
    logic [DW-1:0]   sel_data;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .valid       (req_valid),
        .advance     (transfer),
        .grant_onehot(arb_onehot),
        .grant_idx   (arb_idx)
    );

    // Grants are suppressed while stalled and while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst && !hold) begin
            req_ready = arb_onehot;
        end
    end

    assign transfer = |req_ready;
    assign sel_rd   = req_rd[32'(arb_idx)*AW +: AW];
    assign sel_data = req_data[32'(arb_idx)*DW +: DW];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we     <= 1'b0;
            rf_rd     <= '0;
            rf_data   <= '0;
            grant_idx <= '0;
        end else begin
            // x0 writes still consume the slot but never raise the write enable.
            rf_we <= transfer && (sel_rd != AW'(REG_ZERO));
            if (transfer) begin
                rf_rd     <= sel_rd;
                rf_data   <= sel_data;
                grant_idx <= arb_idx;
            end
        end
    end

    always_comb begin
        wr_pending = '0;
        if (rf_we) begin
            wr_pending[rf_rd] = 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(req_ready));
    a_hold_blocks: assert property (@(posedge clk) disable iff (!rst) hold |-> req_ready == '0);
    a_grant_valid: assert property (@(posedge clk) disable iff (!rst)
        (req_ready & ~req_valid) == '0);
`endif

endmodule
